vector_add_arbiter: RTL and testbench
=====================================

# vector_add_arbiter

Shares one 16-lane fp32 `vector_add` unit (512-bit operands, fixed pipeline latency, no backpressure) between two requesters. Round-robin grants one operand pair per cycle, registers it into the adder, tracks the owner of every in-flight operation in a latency-matched tag pipeline and steers each sum back to its requester. It sits between the aggregation and update engines and the shared adder; it also flags any adder output that does not match its tag pipeline.

## Interface
- `ADD_LATENCY`, 11: adder cycles from `add_in_valid` to `add_res_valid`; must be ≥ 1.
- `DATA_W`, 512: vector width (16 × fp32); data passes through untouched.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req0_valid` in 1: requester 0 has an operand pair.
- `req0_ready` out 1: requester 0 granted this cycle; transfer on `valid & ready`.
- `req0_a`, `req0_b` in DATA_W: requester 0 operands.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`: same for requester 1.
- `add_in_valid` out 1: to adder `s_axis_a/b_tvalid`.
- `add_in_a`, `add_in_b` out DATA_W: to adder `s_axis_a/b_tdata`.
- `add_res_valid` in 1: from adder `m_axis_result_tvalid`.
- `add_res_data` in DATA_W: from adder `m_axis_result_tdata`.
- `res0_valid` out 1: one-cycle pulse carrying a requester 0 sum; no backpressure.
- `res0_data` out DATA_W: requester 0 sum.
- `res1_valid`, `res1_data` out: same for requester 1.
- `idle` out 1: nothing in flight, no drain in progress, no result pending.
- `err` out 1: sticky; adder valid disagreed with the tag pipeline.

## Operation
- Arbiter: `last` register holds the last requester served (reset 1).
  - Only one valid: that requester is granted.
  - Both valid: the requester ≠ `last` is granted.
  - `last` updates only on an accepted transfer.
  - Readies are combinational from valids, `last` and drain state; at most one is high.
  - No ready is asserted while in DRAIN.
- Issue: on acceptance, operands and valid are registered into `add_in_*` on the next edge. `add_in_valid` is 0 in any cycle without acceptance; `add_in_a/b` hold their last value.
- Tag pipeline: ADD_LATENCY stages of {valid, id}. Stage 0 is loaded with {`add_in_valid`, owner} and the pipeline shifts every cycle.
- Result steering: at the last tag stage, compare against `add_res_valid`.
  - Tag valid and `add_res_valid`: register `add_res_data` into `resN_data` and pulse `resN_valid` for N = tag id.
  - Tag valid differs from `add_res_valid`: set `err` (cleared only by `rst`) and drop the data.
- Outstanding counter: width clog2(ADD_LATENCY+2).
  - +1 on acceptance, −1 on matched result; both in one cycle means no change.
  - Never wraps: it is bounded by ADD_LATENCY+1 because only one acceptance occurs per cycle.
- States:
  - DRAIN: entered on reset. The adder has no reset and may still emit results from operations that were in flight.
    - Drain counter runs ADD_LATENCY+1 cycles.
    - `add_res_valid` is ignored (no `err`, no result).
    - Readies are 0.
    - Then go to RUN.
  - RUN: normal operation.
- `idle` = RUN & outstanding==0 & !res0_valid & !res1_valid & !add_in_valid.

## Timing
- Reset values:
  - Ready outputs: 0 (combinational, forced by DRAIN).
  - Outputs held to 0 in reset: `add_in_valid`, `add_in_a/b`, `res*_valid`, `res*_data`, `idle`, `err`.
  - Registers cleared in reset: tag pipeline, outstanding counter.
  - State: DRAIN, drain count 0.
- First grant possible in cycle ADD_LATENCY+1 after `rst` deasserts.
- Acceptance at edge t:
  - `add_in_valid` is high in cycle t+1.
  - `add_res_valid` is expected in cycle t+1+ADD_LATENCY.
  - `resN_valid` is high in cycle t+2+ADD_LATENCY.
- Total request-to-result latency is ADD_LATENCY+2. Full throughput: one result per cycle is sustained.
- Results leave in acceptance order; per-requester order is preserved.
- `rst` mid-operation: all in-flight tags are discarded, and their results are never delivered.

## Test plan
- Reset, then hold `req0_valid`=1: `req0_ready` stays 0 for 12 cycles (ADD_LATENCY=11). After the first acceptance, `res0_valid` rises exactly 13 cycles later with the adder sum, e.g. lanes 1.0+2.0 = 32'h40400000. `err` stays 0.
- Both requesters valid continuously for 8 cycles: grants alternate 0,1,0,1… starting with 0. Results arrive as alternating `res0`/`res1` pulses, back-to-back with no gaps.
- Only `req1_valid` for 5 cycles: 5 consecutive grants to requester 1, no `req0_ready`. Then both valid: next grant goes to requester 0.
- Assert `rst` while 6 operations are in flight, release it: the adder's residual `add_res_valid` pulses produce no `res*_valid` and no `err`. `idle`=1 once DRAIN ends.
- Inject a spurious `add_res_valid` with an empty tag stage in RUN: `err`=1 next cycle and stays 1 until `rst`.
- Single op: `idle` goes 1 → 0 in the cycle after acceptance, and back to 1 the cycle after `res0_valid` drops.

Source files
------------

// File: rtl/vector_add_arbiter_if.sv
// Bundle of requester, shared-adder and result signals around the vector_add arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding logic's view.
interface vector_add_arbiter_if #(
    parameter int DATA_W = 512
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic              add_in_valid;
    logic [DATA_W-1:0] add_in_a;
    logic [DATA_W-1:0] add_in_b;
    logic              add_res_valid;
    logic [DATA_W-1:0] add_res_data;
    logic              res0_valid;
    logic [DATA_W-1:0] res0_data;
    logic              res1_valid;
    logic [DATA_W-1:0] res1_data;
    logic              idle;
    logic              err;

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        input  add_res_valid, add_res_data,
        output req0_ready, req1_ready, add_in_valid, add_in_a, add_in_b,
        output res0_valid, res0_data, res1_valid, res1_data, idle, err
    );

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        output add_res_valid, add_res_data,
        input  req0_ready, req1_ready, add_in_valid, add_in_a, add_in_b,
        input  res0_valid, res0_data, res1_valid, res1_data, idle, err
    );
endinterface

// File: rtl/vector_add_arbiter.sv
// Round-robin sharing of one fixed-latency vector adder between two requesters,
// with a latency-matched owner tag pipeline that steers each sum back to its requester.
module vector_add_arbiter #(
    parameter int ADD_LATENCY = 11,
    parameter int DATA_W      = 512
) (
    input  logic                 clk,
    input  logic                 rst,
    vector_add_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(ADD_LATENCY + 2);

    typedef enum logic [0:0] {
        ST_DRAIN = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  drain_cnt_r;
    logic [CNT_W-1:0]  outst_r;
    logic              last_r;
    logic              run_s;
    logic              grant0_s;
    logic              grant1_s;
    logic              accept_s;
    logic              add_in_valid_r;
    logic              add_in_id_r;
    logic [DATA_W-1:0] add_in_a_r;
    logic [DATA_W-1:0] add_in_b_r;
    logic [ADD_LATENCY-1:0] tag_valid_r;
    logic [ADD_LATENCY-1:0] tag_id_r;
    logic              match_s;
    logic              mismatch_s;
    logic              res0_valid_r;
    logic              res1_valid_r;
    logic [DATA_W-1:0] res0_data_r;
    logic [DATA_W-1:0] res1_data_r;
    logic              err_r;
    logic              idle_s;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_DRAIN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: DRAIN lasts ADD_LATENCY+1 cycles so stale adder outputs die out
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_DRAIN: begin
                if (drain_cnt_r == CNT_W'(ADD_LATENCY)) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_DRAIN;
        endcase
    end

    // Output decode: grants only in RUN, the requester other than last wins a tie
    always_comb begin
        run_s = 1'b0;
        case (state_r)
            ST_RUN:  run_s = 1'b1;
            ST_DRAIN: run_s = 1'b0;
            default: run_s = 1'b0;
        endcase
        grant0_s = run_s & bus.req0_valid & (~bus.req1_valid | last_r);
        grant1_s = run_s & bus.req1_valid & (~bus.req0_valid | ~last_r);
        accept_s = grant0_s | grant1_s;
    end

    // Drain cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_cnt_r <= CNT_W'(0);
        end else if (state_r == ST_DRAIN) begin
            drain_cnt_r <= drain_cnt_r + CNT_W'(1);
        end else begin
            drain_cnt_r <= drain_cnt_r;
        end
    end

    // Arbiter history and operand issue register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_r         <= 1'b1;
            add_in_valid_r <= 1'b0;
            add_in_id_r    <= 1'b0;
            add_in_a_r     <= {DATA_W{1'b0}};
            add_in_b_r     <= {DATA_W{1'b0}};
        end else begin
            add_in_valid_r <= accept_s;
            if (accept_s) begin
                last_r      <= grant1_s;
                add_in_id_r <= grant1_s;
                add_in_a_r  <= grant1_s ? bus.req1_a : bus.req0_a;
                add_in_b_r  <= grant1_s ? bus.req1_b : bus.req0_b;
            end else begin
                last_r      <= last_r;
                add_in_id_r <= add_in_id_r;
                add_in_a_r  <= add_in_a_r;
                add_in_b_r  <= add_in_b_r;
            end
        end
    end

    // Owner tag pipeline, aligned so its last stage meets the adder's result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid_r <= {ADD_LATENCY{1'b0}};
            tag_id_r    <= {ADD_LATENCY{1'b0}};
        end else begin
            tag_valid_r[0] <= add_in_valid_r;
            tag_id_r[0]    <= add_in_id_r;
            for (int i = 1; i < ADD_LATENCY; i++) begin
                tag_valid_r[i] <= tag_valid_r[i-1];
                tag_id_r[i]    <= tag_id_r[i-1];
            end
        end
    end

    assign match_s    = run_s & tag_valid_r[ADD_LATENCY-1] & bus.add_res_valid;
    assign mismatch_s = run_s & (tag_valid_r[ADD_LATENCY-1] != bus.add_res_valid);

    // Result steering and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res0_valid_r <= 1'b0;
            res1_valid_r <= 1'b0;
            res0_data_r  <= {DATA_W{1'b0}};
            res1_data_r  <= {DATA_W{1'b0}};
            err_r        <= 1'b0;
        end else begin
            res0_valid_r <= match_s & ~tag_id_r[ADD_LATENCY-1];
            res1_valid_r <= match_s &  tag_id_r[ADD_LATENCY-1];
            if (match_s & ~tag_id_r[ADD_LATENCY-1]) begin
                res0_data_r <= bus.add_res_data;
            end else begin
                res0_data_r <= res0_data_r;
            end
            if (match_s & tag_id_r[ADD_LATENCY-1]) begin
                res1_data_r <= bus.add_res_data;
            end else begin
                res1_data_r <= res1_data_r;
            end
            err_r <= err_r | mismatch_s;
        end
    end

    // Outstanding operation count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outst_r <= CNT_W'(0);
        end else begin
            case ({accept_s, match_s})
                2'b10:   outst_r <= outst_r + CNT_W'(1);
                2'b01:   outst_r <= outst_r - CNT_W'(1);
                default: outst_r <= outst_r;
            endcase
        end
    end

    // Idle decode from registered state only
    always_comb begin
        idle_s = 1'b0;
        if ((state_r == ST_RUN) && (outst_r == CNT_W'(0)) && !res0_valid_r &&
            !res1_valid_r && !add_in_valid_r) begin
            idle_s = 1'b1;
        end else begin
            idle_s = 1'b0;
        end
    end

    assign bus.req0_ready   = grant0_s;
    assign bus.req1_ready   = grant1_s;
    assign bus.add_in_valid = add_in_valid_r;
    assign bus.add_in_a     = add_in_a_r;
    assign bus.add_in_b     = add_in_b_r;
    assign bus.res0_valid   = res0_valid_r;
    assign bus.res0_data    = res0_data_r;
    assign bus.res1_valid   = res1_valid_r;
    assign bus.res1_data    = res1_data_r;
    assign bus.idle         = idle_s;
    assign bus.err          = err_r;
endmodule

// File: tb/tb_vector_add_arbiter.sv
// Randomized bench: a fixed-latency fp32 adder model feeds the arbiter, and a
// cycle-indexed scoreboard predicts grants, result pulses, idle and err.
module tb_vector_add_arbiter;
    localparam int L      = 11;
    localparam int DATA_W = 512;
    localparam int LANES  = DATA_W / 32;

    typedef struct {
        int                due;
        bit                id;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic clk;
    logic rst;
    logic inject;
    int   n_checks;
    int   n_fail;
    int   cyc;
    bit   ref_last;
    bit   err_exp;
    logic [DATA_W-1:0] last_res0;
    exp_t q[$];

    logic              adder_v [L];
    logic [DATA_W-1:0] adder_d [L];

    vector_add_arbiter_if #(.DATA_W(DATA_W)) bus ();

    vector_add_arbiter #(.ADD_LATENCY(L), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic real f32_to_real(input logic [31:0] x);
        logic [10:0] e;
        if (x[30:23] == 8'h00) return 0.0;
        e = {3'b000, x[30:23]} + 11'd896;
        return $bitstoreal({x[31], e, x[22:0], 29'h0});
    endfunction

    function automatic logic [31:0] real_to_f32(input real r);
        logic [63:0] b;
        logic [10:0] e;
        b = $realtobits(r);
        if (b[62:52] == 11'd0) return 32'h0;
        e = b[62:52] - 11'd896;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    function automatic logic [DATA_W-1:0] vsum(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] s;
        s = '0;
        for (int i = 0; i < LANES; i++)
            s[i*32 +: 32] = real_to_f32(f32_to_real(a[i*32 +: 32]) + f32_to_real(b[i*32 +: 32]));
        return s;
    endfunction

    function automatic logic [DATA_W-1:0] rand_vec();
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < LANES; i++)
            v[i*32 +: 32] = real_to_f32(real'($urandom_range(0, 1000)));
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] fill_vec(input logic [31:0] lane);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < LANES; i++) v[i*32 +: 32] = lane;
        return v;
    endfunction

    // Shared adder model: fixed latency, no reset, optional spurious valid
    always @(posedge clk) begin
        adder_v[0] <= bus.add_in_valid;
        adder_d[0] <= vsum(bus.add_in_a, bus.add_in_b);
        for (int i = 1; i < L; i++) begin
            adder_v[i] <= adder_v[i-1];
            adder_d[i] <= adder_d[i-1];
        end
    end
    assign bus.add_res_valid = adder_v[L-1] | inject;
    assign bus.add_res_data  = adder_d[L-1];

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive, predict, compare, advance
    task automatic run_cycle(input bit v0, input bit v1, input bit inj, input bit directed);
        logic [DATA_W-1:0] a0, b0, a1, b1;
        bit run, g0, g1, pend, r0e, r1e;
        a0 = rand_vec(); b0 = rand_vec(); a1 = rand_vec(); b1 = rand_vec();
        if (directed) begin
            a0 = fill_vec(32'h3f800000);
            b0 = fill_vec(32'h40000000);
        end
        bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0;
        bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1;
        inject = inj;
        #4;
        run = (cyc >= L + 1);
        g0 = run && v0 && (!v1 || ref_last);
        g1 = run && v1 && (!v0 || !ref_last);
        check_eq("req0_ready", DATA_W'(bus.req0_ready), DATA_W'(g0));
        check_eq("req1_ready", DATA_W'(bus.req1_ready), DATA_W'(g1));
        pend = 0;
        foreach (q[i]) if (q[i].due - (L + 1) <= cyc) pend = 1;
        check_eq("idle", DATA_W'(bus.idle), DATA_W'(run && !pend));
        check_eq("err", DATA_W'(bus.err), DATA_W'(err_exp));
        r0e = 0; r1e = 0;
        if (q.size() > 0 && q[0].due == cyc) begin
            if (q[0].id) r1e = 1; else r0e = 1;
        end
        check_eq("res0_valid", DATA_W'(bus.res0_valid), DATA_W'(r0e));
        check_eq("res1_valid", DATA_W'(bus.res1_valid), DATA_W'(r1e));
        if (r0e) begin
            check_eq("res0_data", bus.res0_data, q[0].data);
            last_res0 = bus.res0_data;
        end
        if (r1e) check_eq("res1_data", bus.res1_data, q[0].data);
        if (r0e || r1e) void'(q.pop_front());
        if (g0 || g1) begin
            q.push_back('{cyc + L + 2, g1, g1 ? vsum(a1, b1) : vsum(a0, b0)});
            ref_last = g1;
        end
        @(posedge clk); #1;
        if (inj && run) err_exp = 1;
        inject = 0;
        cyc++;
    endtask

    task automatic do_reset();
        bus.req0_valid = 0; bus.req1_valid = 0; inject = 0;
        rst = 1;
        repeat (2) begin
            #4;
            check_eq("rst_add_in_valid", DATA_W'(bus.add_in_valid), '0);
            check_eq("rst_res_valid", DATA_W'({bus.res0_valid, bus.res1_valid}), '0);
            check_eq("rst_res0_data", bus.res0_data, '0);
            check_eq("rst_ready", DATA_W'({bus.req0_ready, bus.req1_ready}), '0);
            check_eq("rst_idle_err", DATA_W'({bus.idle, bus.err}), '0);
            @(posedge clk); #1;
        end
        rst = 0;
        q.delete();
        err_exp = 0; ref_last = 1; cyc = 0;
    endtask

    initial begin
        clk = 0; rst = 1; inject = 0;
        n_checks = 0; n_fail = 0; cyc = 0; ref_last = 1; err_exp = 0; last_res0 = '0;
        bus.req0_valid = 0; bus.req1_valid = 0;
        bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
        @(posedge clk); #1;
        do_reset();

        // req0 held from reset: first grant in cycle L+1, single 1.0+2.0 op
        for (int i = 0; i <= L; i++) run_cycle(1, 0, 0, 0);
        run_cycle(1, 0, 0, 1);
        repeat (L + 4) run_cycle(0, 0, 0, 0);
        check_eq("sum_1p0_2p0", DATA_W'(last_res0[31:0]), DATA_W'(32'h40400000));

        // req1 alone, then both: alternating grants and back-to-back results
        repeat (5) run_cycle(0, 1, 0, 0);
        repeat (8) run_cycle(1, 1, 0, 0);
        repeat (L + 4) run_cycle(0, 0, 0, 0);

        // random traffic
        repeat (200) run_cycle(1'($urandom), 1'($urandom), 0, 0);
        repeat (L + 4) run_cycle(0, 0, 0, 0);

        // reset with operations in flight: residual adder outputs are ignored
        repeat (6) run_cycle(1, 1, 0, 0);
        do_reset();
        repeat (L + 6) run_cycle(0, 0, 0, 0);
        repeat (20) run_cycle(1'($urandom), 1'($urandom), 0, 0);
        repeat (L + 4) run_cycle(0, 0, 0, 0);

        // spurious adder valid: sticky err until reset
        run_cycle(0, 0, 1, 0);
        repeat (5) run_cycle(0, 0, 0, 0);
        do_reset();
        repeat (L + 4) run_cycle(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
